// File: rtl/bht_update_sched.sv
// bht_update_sched: update scheduler and misprediction controller for a 2-bit BHT.
//
// Purpose:
//   - Flags a misprediction for each branch resolved in MEM, combinationally.
//     On a misprediction it drives Flush and the corrected Redirect_PC.
//   - Queues one BHT training update {PC, outcome} per resolved branch in a small FIFO.
//   - Arbitrates the BHT's single write port between draining that FIFO and a
//     table-clear sweep.
//
// Optional feature: define BHT_STATS_EN to build the statistics counters.
//   Without it, Br_Count, Mispred_Count and Drop_Count are tied to zero.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   is_Branch_MEM        conditional branch valid in MEM
//   PC_MEM, Target_MEM   branch PC and computed target
//   Predicted_Taken_MEM  prediction carried from IF
//   Actual_Taken         resolved outcome
//   Clear_Req            one-cycle request to sweep every BHT entry back to 2'b01
//   Flush, Redirect_PC   misprediction flush and correct next PC (combinational)
//   Upd_Valid/PC/Taken   registered BHT write port
//   Upd_Clear            registered; force the entry at Upd_PC to 2'b01
//   Clear_Busy           registered; sweep in progress
//   Br_Count, Mispred_Count, Drop_Count  statistics
module bht_update_sched #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned BHT_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        is_Branch_MEM,
    input  logic [31:0] PC_MEM,
    input  logic [31:0] Target_MEM,
    input  logic        Predicted_Taken_MEM,
    input  logic        Actual_Taken,
    input  logic        Clear_Req,
    output logic        Flush,
    output logic [31:0] Redirect_PC,
    output logic        Upd_Valid,
    output logic [31:0] Upd_PC,
    output logic        Upd_Taken,
    output logic        Upd_Clear,
    output logic        Clear_Busy,
    output logic [31:0] Br_Count,
    output logic [31:0] Mispred_Count,
    output logic [15:0] Drop_Count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    // Misprediction path: purely combinational from the MEM inputs.
    logic mispredict;
    assign mispredict  = is_Branch_MEM & (Predicted_Taken_MEM != Actual_Taken);
    assign Flush       = mispredict;
    assign Redirect_PC = Actual_Taken ? Target_MEM : (PC_MEM + 32'd4);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d, count_after_pop;
    logic               upd_valid_q, upd_valid_d;
    logic               upd_clear_q, upd_clear_d;
    logic               upd_taken_q, upd_taken_d;
    logic [31:0]        upd_pc_q, upd_pc_d;

    logic [31:0]        fifo_pc_q [FIFO_DEPTH];
    logic               fifo_tk_q [FIFO_DEPTH];

    logic pop, push, full;

    // The FIFO head is on the Upd_* registers in any IDLE cycle where the FIFO is
    // non-empty. That same cycle counts as its pop.
    assign pop  = (state_q == StIdle) && (count_q != '0);
    assign full = (count_q == CNT_W'(FIFO_DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push = is_Branch_MEM && (!full || pop);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (Clear_Req) begin
                    state_d = StClear;
                    idx_d   = '0;
                end
            end
            StClear: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(BHT_ENTRIES - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_ptr_d        = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d        = wr_ptr_q + PTR_W'(push);
        count_after_pop = count_q - CNT_W'(pop);
        count_d         = count_after_pop + CNT_W'(push);
    end

    // The Upd_* registers are loaded with what the write port shows next cycle. This
    // gives a one-cycle push-to-write latency. If the FIFO empties and is refilled in
    // the same cycle, the new head is the entry being pushed now. That entry is not
    // in storage yet, so it is taken straight from the inputs.
    always_comb begin
        upd_valid_d = 1'b0;
        upd_clear_d = 1'b0;
        upd_pc_d    = upd_pc_q;
        upd_taken_d = upd_taken_q;
        if (state_d == StClear) begin
            upd_valid_d = 1'b1;
            upd_clear_d = 1'b1;
            upd_taken_d = 1'b0;
            upd_pc_d    = 32'({idx_d, 2'b00});
        end else if (count_d != '0) begin
            upd_valid_d = 1'b1;
            if (count_after_pop == '0) begin
                upd_pc_d    = PC_MEM;
                upd_taken_d = Actual_Taken;
            end else begin
                upd_pc_d    = fifo_pc_q[rd_ptr_d];
                upd_taken_d = fifo_tk_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            upd_valid_q <= 1'b0;
            upd_clear_q <= 1'b0;
            upd_pc_q    <= '0;
            upd_taken_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            upd_valid_q <= upd_valid_d;
            upd_clear_q <= upd_clear_d;
            upd_pc_q    <= upd_pc_d;
            upd_taken_q <= upd_taken_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q] <= PC_MEM;
            fifo_tk_q[wr_ptr_q] <= Actual_Taken;
        end
    end

    assign Upd_Valid  = upd_valid_q;
    assign Upd_Clear  = upd_clear_q;
    assign Upd_PC     = upd_pc_q;
    assign Upd_Taken  = upd_taken_q;
    assign Clear_Busy = (state_q == StClear);

`ifdef BHT_STATS_EN
    logic        drop;
    logic [31:0] br_cnt_q, mis_cnt_q;
    logic [15:0] drop_cnt_q;

    assign drop = is_Branch_MEM && !push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q   <= '0;
            mis_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_q + 32'(is_Branch_MEM);
            mis_cnt_q <= mis_cnt_q + 32'(mispredict);
            if (drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign Br_Count      = br_cnt_q;
    assign Mispred_Count = mis_cnt_q;
    assign Drop_Count    = drop_cnt_q;
`else
    assign Br_Count      = '0;
    assign Mispred_Count = '0;
    assign Drop_Count    = '0;
`endif

endmodule

// File: tb/tb_bht_update_sched.sv
// Self-checking bench for bht_update_sched.
// - The stimulus is a directed sequence of steps in a single initial block.
// - Expected BHT training writes go into a queue when each branch is driven.
// - Queued entries are popped and compared when the DUT raises Upd_Valid.
// - Sweep writes are predicted from a bench-side sweep counter.
module tb_bht_update_sched;

    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int unsigned BHT_ENTRIES = 64;
`ifdef BHT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk, rst_n;
    logic        is_Branch_MEM, Predicted_Taken_MEM, Actual_Taken, Clear_Req;
    logic [31:0] PC_MEM, Target_MEM;
    logic        Flush, Upd_Valid, Upd_Taken, Upd_Clear, Clear_Busy;
    logic [31:0] Redirect_PC, Upd_PC, Br_Count, Mispred_Count;
    logic [15:0] Drop_Count;

    bht_update_sched #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .BHT_ENTRIES (BHT_ENTRIES)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .is_Branch_MEM       (is_Branch_MEM),
        .PC_MEM              (PC_MEM),
        .Target_MEM          (Target_MEM),
        .Predicted_Taken_MEM (Predicted_Taken_MEM),
        .Actual_Taken        (Actual_Taken),
        .Clear_Req           (Clear_Req),
        .Flush               (Flush),
        .Redirect_PC         (Redirect_PC),
        .Upd_Valid           (Upd_Valid),
        .Upd_PC              (Upd_PC),
        .Upd_Taken           (Upd_Taken),
        .Upd_Clear           (Upd_Clear),
        .Clear_Busy          (Clear_Busy),
        .Br_Count            (Br_Count),
        .Mispred_Count       (Mispred_Count),
        .Drop_Count          (Drop_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [32:0] exp_q [$];   // {pc, taken}
    int          sweep_left = 0;
    int          sweep_idx  = 0;
    bit          busy_now   = 1'b0;   // DUT is in CLEAR during the cycle being driven
    int unsigned br_exp = 0, mis_exp = 0, drop_exp = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_stats();
        chk("br_count", Br_Count, STATS ? 32'(br_exp) : 32'd0);
        chk("mispred_count", Mispred_Count, STATS ? 32'(mis_exp) : 32'd0);
        chk("drop_count", 32'(Drop_Count), STATS ? 32'(drop_exp) : 32'd0);
    endtask

    // Compare the registered outputs of the cycle that just started.
    task automatic check_outputs();
        logic [32:0] e;
        busy_now = (sweep_left > 0);
        chk("clear_busy", 32'(Clear_Busy), 32'(busy_now));
        if (busy_now) begin
            chk("sweep_valid", 32'(Upd_Valid), 32'd1);
            chk("sweep_clear", 32'(Upd_Clear), 32'd1);
            chk("sweep_taken", 32'(Upd_Taken), 32'd0);
            chk("sweep_pc", Upd_PC, 32'(sweep_idx) << 2);
            sweep_idx++;
            sweep_left--;
        end else begin
            chk("upd_valid", 32'(Upd_Valid), 32'(exp_q.size() != 0));
            chk("upd_clear", 32'(Upd_Clear), 32'd0);
            if (Upd_Valid && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("upd_pc", Upd_PC, e[32:1]);
                chk("upd_taken", 32'(Upd_Taken), 32'(e[0]));
            end
        end
        check_stats();
    endtask

    // One clock cycle. Inputs are driven 1 time unit after an edge, the
    // combinational outputs are checked 1 unit later, and the registered outputs
    // are checked 1 unit after the next edge.
    task automatic step(input logic br, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic pred, input logic act, input logic clr);
        bit exp_flush;
        bit clr_go;
        is_Branch_MEM       = br;
        PC_MEM              = pc;
        Target_MEM          = tgt;
        Predicted_Taken_MEM = pred;
        Actual_Taken        = act;
        Clear_Req           = clr;
        #1;
        exp_flush = br && (pred != act);
        chk("flush", 32'(Flush), 32'(exp_flush));
        if (exp_flush) chk("redirect_pc", Redirect_PC, act ? tgt : pc + 32'd4);
        if (br) begin
            br_exp++;
            if (busy_now && exp_q.size() >= FIFO_DEPTH) drop_exp++;
            else exp_q.push_back({pc, act});
        end
        if (exp_flush) mis_exp++;
        clr_go = clr && !busy_now;
        @(posedge clk);
        #1;
        if (clr_go) begin
            sweep_left = BHT_ENTRIES;
            sweep_idx  = 0;
        end
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_values();
        chk("rst_valid", 32'(Upd_Valid), 32'd0);
        chk("rst_clear", 32'(Upd_Clear), 32'd0);
        chk("rst_pc", Upd_PC, 32'd0);
        chk("rst_taken", 32'(Upd_Taken), 32'd0);
        chk("rst_busy", 32'(Clear_Busy), 32'd0);
        check_stats();
    endtask

    initial begin
        rst_n = 1'b0;
        is_Branch_MEM = 1'b0; PC_MEM = '0; Target_MEM = '0;
        Predicted_Taken_MEM = 1'b0; Actual_Taken = 1'b0; Clear_Req = 1'b0;
        #2;
        check_reset_values();
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Correct prediction; the write appears in the next cycle.
        step(1'b1, 32'h100, 32'h500, 1'b1, 1'b1, 1'b0);
        idle(1);
        // Mispredicted not-taken, then mispredicted taken with a wrapping PC.
        step(1'b1, 32'h200, 32'h80, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hFFFF_FFFC, 32'h40, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'hFFFF_FFFC, 32'h40, 1'b1, 1'b0, 1'b0);
        // Prediction mismatch without a valid branch: no flush, no push.
        step(1'b0, 32'h300, 32'h44, 1'b1, 1'b0, 1'b0);
        // Back-to-back branches with mixed outcomes.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h1000 + 32'(i * 8), 32'h2000, i[0], i[1], 1'b0);
        end
        idle(2);

        // Sweep with an overflowing burst and an ignored re-request.
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'h4000 + 32'(i * 4), 32'h8000, 1'b0, i[0], 1'b0);
        end
        idle(12);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        while (sweep_left > 0) idle(1);
        // First drain cycle: the FIFO is full, and a push alongside the pop is accepted.
        step(1'b1, 32'h5000, 32'h6000, 1'b1, 1'b1, 1'b0);
        idle(6);

        // Reset asserted mid-sweep once idx 20 has been written.
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h7000, 32'h7100, 1'b0, 1'b1, 1'b0);
        while (sweep_idx <= 20) idle(1);
        #2 rst_n = 1'b0;
        exp_q.delete();
        sweep_left = 0;
        sweep_idx  = 0;
        busy_now   = 1'b0;
        br_exp = 0; mis_exp = 0; drop_exp = 0;
        #1;
        check_reset_values();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(4);
        step(1'b1, 32'h900, 32'h0, 1'b0, 1'b0, 1'b0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bht_update_sched.md
# bht_update_sched

Update scheduler and misprediction controller for the 2-bit branch history table (BHT). It evaluates each branch resolved in MEM, raises a same-cycle flush and redirect on misprediction, and queues BHT training updates in a small FIFO. It also arbitrates the BHT's single write port between training updates and a table-clear sweep requested by the core.

## Interface
Parameters:
- FIFO_DEPTH, 4, update queue entries; power of 2, ≥2
- BHT_ENTRIES, 64, BHT size; power of 2; index = PC[log2(BHT_ENTRIES)+1:2]

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- is_Branch_MEM  in  1  conditional branch valid in MEM
- PC_MEM  in  32  branch PC
- Target_MEM  in  32  computed branch target
- Predicted_Taken_MEM  in  1  prediction carried down the pipe from IF
- Actual_Taken  in  1  resolved outcome
- Clear_Req  in  1  single-cycle request to reset all BHT entries to 2'b01
- Flush  out  1  misprediction; flush IF/ID/EX
- Redirect_PC  out  32  correct next PC when Flush=1
- Upd_Valid  out  1  BHT write strobe
- Upd_PC  out  32  BHT write address (PC form)
- Upd_Taken  out  1  outcome to train with
- Upd_Clear  out  1  force entry at Upd_PC to 2'b01 (overrides training)
- Clear_Busy  out  1  sweep in progress
- Br_Count  out  32  resolved branches (stats)
- Mispred_Count  out  32  mispredictions (stats)
- Drop_Count  out  16  updates lost to overflow (stats)

## Operation
- Mispredict = is_Branch_MEM & (Predicted_Taken_MEM != Actual_Taken). This signal is combinational.
- Flush = Mispredict.
- Redirect_PC = Actual_Taken ? Target_MEM : PC_MEM + 4, mod 2^32. The value is don't-care when Flush=0.
- Enqueue: every cycle with is_Branch_MEM=1 pushes {PC_MEM, Actual_Taken}, whether or not the prediction was correct.
- State machine has two states: IDLE and CLEAR.
  - IDLE: if the FIFO is non-empty, pop one entry per cycle and present it on the Upd_* outputs. Upd_Clear=0.
  - IDLE → CLEAR when Clear_Req=1. Sweep index resets to 0.
  - CLEAR: Upd_Valid=1, Upd_Clear=1, Upd_Taken=0, Upd_PC={zeros, idx, 2'b00}. idx increments every cycle.
  - CLEAR → IDLE after the cycle with idx=BHT_ENTRIES-1, so a sweep lasts exactly BHT_ENTRIES cycles.
  - FIFO pops are suspended during CLEAR. Pushes continue.
- Clear_Req while in CLEAR is ignored; there is no re-trigger.
- Queued entries drain after the sweep finishes, so they train the freshly cleared table. This ordering is intended.
- Full FIFO:
  - In IDLE, a push in the same cycle as a pop is accepted.
  - In CLEAR, a push is dropped and Drop_Count increments.
- Empty FIFO in IDLE: Upd_Valid=0, Upd_Clear=0.
- Upd_PC and Upd_Taken hold their last values when Upd_Valid=0.

## Timing
- Flush and Redirect_PC: 0-cycle latency, combinational from MEM inputs.
- Update latency: a push in cycle N (IDLE, FIFO empty) produces Upd_Valid=1 in cycle N+1. There is no bypass.
- Clear: Clear_Req=1 in cycle N gives Clear_Busy=1 and the idx=0 write in cycles N+1 through N+BHT_ENTRIES. Clear_Busy=0 and normal drain resume at N+BHT_ENTRIES+1.
- Upd_* and Clear_Busy are registered outputs.
- Reset values (async assert): state=IDLE, FIFO empty, Upd_Valid=0, Upd_Clear=0, Upd_PC=0, Upd_Taken=0, Clear_Busy=0, all counters 0. Flush follows its inputs.
- Reset mid-sweep aborts the sweep and discards queued updates. The BHT's own reset value (01) makes the table consistent.

## Configuration
- BHT_STATS_EN defined:
  - Br_Count increments on each is_Branch_MEM=1 cycle.
  - Mispred_Count increments on each Mispredict=1 cycle.
  - Both wrap mod 2^32.
  - Drop_Count saturates at 16'hFFFF.
- BHT_STATS_EN undefined: counters are not built, and the three stats ports are tied to 0. Ports remain so the instantiation is unchanged.

## Test plan
- Correct branch: is_Branch_MEM=1, PC_MEM=0x100, Pred=1, Actual=1 → Flush=0. Next cycle Upd_Valid=1, Upd_PC=0x100, Upd_Taken=1.
- Mispredict not-taken: PC_MEM=0x200, Target=0x80, Pred=1, Actual=0 → same cycle Flush=1, Redirect_PC=0x204. With BHT_STATS_EN, Mispred_Count=1.
- Mispredict taken: PC_MEM=0xFFFFFFFC, Pred=0, Actual=1, Target=0x40 → Flush=1, Redirect_PC=0x40. Not-taken case wraps: Redirect_PC=0x00000000.
- Clear sweep: Clear_Req pulse in cycle 10 → Upd_Clear=1 with Upd_PC=0x0,0x4,…,0xFC in cycles 11–74; Clear_Busy drops at 75. A second Clear_Req at cycle 30 has no effect.
- Overflow: start a sweep, then push 6 branches → first 4 are queued, Drop_Count=2. After the sweep, the 4 entries drain in order in cycles 75–78.
- Async reset asserted mid-sweep at idx=20 → Upd_Valid=0, Clear_Busy=0, FIFO empty immediately. After release, no writes occur until a new branch or Clear_Req.
